// File: rtl/bt656_rx_if.sv
// BT.656 receive bus: byte stream in, qualified active video, position and status out.
interface bt656_rx_if;
  logic [7:0]  i_Data;
  logic        i_DataValid;
  logic [7:0]  o_Data;
  logic        o_DataValid;
  logic [15:0] o_PixelCount;
  logic [15:0] o_LineCount;
  logic        o_Fsignal;
  logic        o_Vsignal;
  logic        o_Hsignal;
  logic        o_SavDetected;
  logic        o_EavDetected;
  logic        o_ProtErr;
  logic        o_LenErr;
  logic        o_Locked;

  // Stream source / status consumer side.
  modport master (
    output i_Data, i_DataValid,
    input  o_Data, o_DataValid, o_PixelCount, o_LineCount, o_Fsignal, o_Vsignal, o_Hsignal,
           o_SavDetected, o_EavDetected, o_ProtErr, o_LenErr, o_Locked
  );

  // Decoder side.
  modport slave (
    input  i_Data, i_DataValid,
    output o_Data, o_DataValid, o_PixelCount, o_LineCount, o_Fsignal, o_Vsignal, o_Hsignal,
           o_SavDetected, o_EavDetected, o_ProtErr, o_LenErr, o_Locked
  );
endinterface

// File: rtl/bt656_rx.sv
// BT.656 receive decoder: finds FF 00 00 XY timing codes, checks protection bits,
// forwards active video bytes and tracks line position and lock.
module bt656_rx #(
  parameter int unsigned HACT_PIXELS = 1440,
  parameter int unsigned LOCK_LINES  = 4
) (
  input logic         i_SysClock,
  input logic         i_ResetN,
  bt656_rx_if.slave   bus
);

  localparam logic [16:0] HactPixels = 17'(HACT_PIXELS);
  localparam logic [7:0]  LockLines  = 8'(LOCK_LINES);

  typedef enum logic [1:0] {StSearch, StGotFf, StGot00a, StGot00b} syncState_e;

  syncState_e  stateQ, stateD;
  logic        activeQ, activeD;
  logic        lenArmQ, lenArmD;
  logic [16:0] cntQ, cntD;
  logic [15:0] lineQ, lineD;
  logic [7:0]  goodQ, goodD, goodInc;
  logic        lockedQ, lockedD;
  logic        fQ, vQ, hQ;
  logic        savQ, eavQ, protQ, lenQ;
  logic [7:0]  dataQ;
  logic        dataValidQ;
  logic [15:0] pixQ;

  logic [7:0]  din;
  logic        dv, isXy, xyF, xyV, xyH, xyOk;
  logic        savOk, eavOk, protBad, lenErr, fwd;

  assign din  = bus.i_Data;
  assign dv   = bus.i_DataValid;
  assign isXy = dv && (stateQ == StGot00b);
  assign xyF  = din[6];
  assign xyV  = din[5];
  assign xyH  = din[4];
  assign xyOk = din[7] && (din[3:0] == {xyV ^ xyH, xyF ^ xyH, xyF ^ xyV, xyF ^ xyV ^ xyH});

  assign savOk   = isXy && xyOk && !xyH;
  assign eavOk   = isXy && xyOk && xyH;
  assign protBad = isXy && !xyOk;
  // Length is only meaningful for a line opened by an active-video SAV.
  assign lenErr  = eavOk && lenArmQ && (cntQ != HactPixels);
  assign goodInc = (goodQ == 8'hFF) ? goodQ : goodQ + 8'd1;

  // Sync preamble FSM, advancing on valid bytes only.
  always_comb begin
    stateD = stateQ;
    if (dv) begin
      unique case (stateQ)
        StSearch: stateD = (din == 8'hFF) ? StGotFf : StSearch;
        StGotFf: begin
          if (din == 8'h00)      stateD = StGot00a;
          else if (din == 8'hFF) stateD = StGotFf;
          else                   stateD = StSearch;
        end
        StGot00a: begin
          if (din == 8'h00)      stateD = StGot00b;
          else if (din == 8'hFF) stateD = StGotFf;
          else                   stateD = StSearch;
        end
        StGot00b: stateD = (din == 8'hFF) ? StGotFf : StSearch;
        default:  stateD = StSearch;
      endcase
    end
  end

  // Active window, byte counter and forwarding decision.
  always_comb begin
    activeD = activeQ;
    lenArmD = lenArmQ;
    cntD    = cntQ;
    fwd     = 1'b0;
    if (dv && activeQ) begin
      if (din == 8'hFF) begin
        activeD = 1'b0;
      end else if (din != 8'h00) begin
        fwd = (cntQ < HactPixels);
        // Keep counting past the line length so over-long lines still fail the check.
        if (cntQ != '1) cntD = cntQ + 17'd1;
      end
    end
    if (savOk) begin
      activeD = !xyV;
      lenArmD = !xyV;
      cntD    = '0;
    end
    if (eavOk || protBad) begin
      activeD = 1'b0;
      lenArmD = 1'b0;
    end
  end

  // Line counter and good-line lock tracking.
  always_comb begin
    lineD   = lineQ;
    goodD   = goodQ;
    lockedD = lockedQ;
    if (eavOk) lineD = (xyF != fQ) ? 16'd0 : lineQ + 16'd1;
    if (protBad || lenErr) begin
      goodD   = '0;
      lockedD = 1'b0;
    end else if (eavOk) begin
      goodD = goodInc;
      if (goodInc >= LockLines) lockedD = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      stateQ     <= StSearch;
      activeQ    <= 1'b0;
      lenArmQ    <= 1'b0;
      cntQ       <= '0;
      lineQ      <= '0;
      goodQ      <= '0;
      lockedQ    <= 1'b0;
      fQ         <= 1'b0;
      vQ         <= 1'b0;
      hQ         <= 1'b0;
      savQ       <= 1'b0;
      eavQ       <= 1'b0;
      protQ      <= 1'b0;
      lenQ       <= 1'b0;
      dataQ      <= '0;
      dataValidQ <= 1'b0;
      pixQ       <= '0;
    end else begin
      stateQ     <= stateD;
      activeQ    <= activeD;
      lenArmQ    <= lenArmD;
      cntQ       <= cntD;
      lineQ      <= lineD;
      goodQ      <= goodD;
      lockedQ    <= lockedD;
      savQ       <= savOk;
      eavQ       <= eavOk;
      protQ      <= protBad;
      lenQ       <= lenErr;
      dataValidQ <= fwd;
      if (isXy && xyOk) begin
        fQ <= xyF;
        vQ <= xyV;
        hQ <= xyH;
      end
      if (fwd) begin
        dataQ <= din;
        pixQ  <= cntQ[15:0];
      end
    end
  end

  assign bus.o_Data        = dataQ;
  assign bus.o_DataValid   = dataValidQ;
  assign bus.o_PixelCount  = pixQ;
  assign bus.o_LineCount   = lineQ;
  assign bus.o_Fsignal     = fQ;
  assign bus.o_Vsignal     = vQ;
  assign bus.o_Hsignal     = hQ;
  assign bus.o_SavDetected = savQ;
  assign bus.o_EavDetected = eavQ;
  assign bus.o_ProtErr     = protQ;
  assign bus.o_LenErr      = lenQ;
  assign bus.o_Locked      = lockedQ;

endmodule

// File: tb/tb_bt656_rx.sv
// Scoreboard bench for bt656_rx: stimulus pushes expected bytes/events, a monitor pops them.
module tb_bt656_rx;
  logic clk = 1'b0;
  logic rstN = 1'b0;

  bt656_rx_if bus ();

  bt656_rx #(
    .HACT_PIXELS(1440),
    .LOCK_LINES (4)
  ) dut (
    .i_SysClock(clk),
    .i_ResetN  (rstN),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Event word: {sav, eav, prot, len, f, v, h, locked, line[15:0]}
  logic [23:0] evQ[$];
  // Pixel word: {pixelCount[15:0], data[7:0]}
  logic [23:0] pxQ[$];
  int nChecks = 0;
  int nPass   = 0;
  bit gapMode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or an event pulse.
  always @(negedge clk) begin
    logic [23:0] e;
    if (bus.o_DataValid === 1'b1) begin
      if (pxQ.size() == 0) check("extra_byte", 64'(pxQ.size()), 64'd1);
      else begin
        e = pxQ.pop_front();
        check("pixel_data", 64'(bus.o_Data), 64'(e[7:0]));
        check("pixel_count", 64'(bus.o_PixelCount), 64'(e[23:8]));
      end
    end
    if ((bus.o_SavDetected | bus.o_EavDetected | bus.o_ProtErr | bus.o_LenErr) === 1'b1) begin
      if (evQ.size() == 0) check("extra_event", 64'(evQ.size()), 64'd1);
      else begin
        e = evQ.pop_front();
        check("event", 64'({bus.o_SavDetected, bus.o_EavDetected, bus.o_ProtErr, bus.o_LenErr,
                            bus.o_Fsignal, bus.o_Vsignal, bus.o_Hsignal, bus.o_Locked,
                            bus.o_LineCount}), 64'(e));
      end
    end
  end

  task automatic pushEv(input bit sav, input bit eav, input bit prot, input bit len, input bit f,
                        input bit v, input bit h, input bit locked, input logic [15:0] line);
    evQ.push_back({sav, eav, prot, len, f, v, h, locked, line});
  endtask

  task automatic sendByte(input logic [7:0] b);
    if (gapMode) begin
      bus.i_Data      = 8'h55;
      bus.i_DataValid = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_Data      = b;
    bus.i_DataValid = 1'b1;
    @(posedge clk); #1;
    bus.i_DataValid = 1'b0;
  endtask

  task automatic sendTrs(input logic [7:0] xy);
    sendByte(8'hFF);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(xy);
  endtask

  // Active bytes cycle 0x10..0xEF; optionally expected at the output.
  task automatic sendActive(input int n, input bit expectOut);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'h10 + 8'(i % 224);
      if (expectOut) pxQ.push_back({16'(i), b});
      sendByte(b);
    end
  endtask

  task automatic checkIdle();
    check("idle_outputs",
          64'({bus.o_Data, bus.o_DataValid, bus.o_PixelCount, bus.o_LineCount, bus.o_Fsignal,
               bus.o_Vsignal, bus.o_Hsignal, bus.o_SavDetected, bus.o_EavDetected,
               bus.o_ProtErr, bus.o_LenErr, bus.o_Locked}), 64'd0);
  endtask

  task automatic drain();
    int t = 0;
    while ((pxQ.size() != 0 || evQ.size() != 0) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("pixel_queue_empty", 64'(pxQ.size()), 64'd0);
    check("event_queue_empty", 64'(evQ.size()), 64'd0);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkIdle();
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checkIdle();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.i_Data      = 8'h00;
    bus.i_DataValid = 1'b0;
    @(negedge clk);
    checkIdle();
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checkIdle();
    @(posedge clk); #1;

    // Full good line.
    pushEv(1, 0, 0, 0, 0, 0, 0, 0, 16'd0);
    sendTrs(8'h80);
    sendActive(1440, 1'b1);
    pushEv(0, 1, 0, 0, 0, 0, 1, 0, 16'd1);
    sendTrs(8'h9D);

    // Bad protection: flags held, nothing forwarded afterwards.
    pushEv(0, 0, 1, 0, 0, 0, 1, 0, 16'd1);
    sendTrs(8'h81);
    sendActive(20, 1'b0);

    // Short line: length error together with EAV.
    pushEv(1, 0, 0, 0, 0, 0, 0, 0, 16'd1);
    sendTrs(8'h80);
    sendActive(1000, 1'b1);
    pushEv(0, 1, 0, 1, 0, 0, 1, 0, 16'd2);
    sendTrs(8'h9D);
    drain();
    doReset();

    // Five good lines: lock at the 4th EAV, then a field change.
    for (int k = 1; k <= 5; k++) begin
      pushEv(1, 0, 0, 0, 0, 0, 0, (k >= 5), 16'(k - 1));
      sendTrs(8'h80);
      sendActive(1440, 1'b1);
      pushEv(0, 1, 0, 0, 0, 0, 1, (k >= 4), 16'(k));
      sendTrs(8'h9D);
    end
    pushEv(0, 1, 0, 0, 1, 1, 1, 1, 16'd0);
    sendTrs(8'hF1);

    // Every other cycle idle, including inside the preambles.
    gapMode = 1'b1;
    pushEv(1, 0, 0, 0, 0, 0, 0, 1, 16'd0);
    sendTrs(8'h80);
    sendActive(1440, 1'b1);
    pushEv(0, 1, 0, 0, 0, 0, 1, 1, 16'd1);
    sendTrs(8'h9D);
    gapMode = 1'b0;

    // Reset mid-line: remainder of the line must be dropped.
    pushEv(1, 0, 0, 0, 0, 0, 0, 1, 16'd1);
    sendTrs(8'h80);
    sendActive(500, 1'b1);
    drain();
    doReset();
    sendActive(940, 1'b0);
    pushEv(0, 1, 0, 0, 0, 0, 1, 0, 16'd1);
    sendTrs(8'h9D);
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
